// File: rtl/j1_code_loader_if.sv
// Byte-stream input and code RAM write port of the J1 code loader.
// The loader takes the slave side; the UART/RAM environment takes the master side.
interface j1_code_loader_if #(
    parameter int ADDR_W = 13
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              ram_sel;
    logic [ADDR_W-1:0] ram_addr;
    logic [15:0]       ram_wdata;
    logic              ram_we;

    modport master (
        output in_data, in_valid,
        input  in_ready, ram_sel, ram_addr, ram_wdata, ram_we
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, ram_sel, ram_addr, ram_wdata, ram_we
    );
endinterface

// File: rtl/j1_code_loader.sv
// Boot/reload sequencer for the J1: receives a framed image over a byte stream,
// writes it into code RAM while holding the CPU in reset, then releases it on a good checksum.
module j1_code_loader #(
    parameter int         ADDR_W        = 13,
    parameter bit         HOLD_AT_RESET = 1'b1,
    parameter logic [7:0] SYNC_BYTE     = 8'hA5
) (
    input  logic              clk,
    input  logic              resetq,
    j1_code_loader_if.slave   bus,
    output logic              cpu_resetq,
    output logic              busy,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded,
    output logic [3:0]        fsm_state
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_ADDR_H = 4'd1,
        S_ADDR_L = 4'd2,
        S_CNT_H  = 4'd3,
        S_CNT_L  = 4'd4,
        S_DATA_H = 4'd5,
        S_DATA_L = 4'd6,
        S_WRITE  = 4'd7,
        S_CSUM   = 4'd8
    } state_t;

    state_t            state;
    logic              ram_sel;
    logic [ADDR_W-1:0] ram_addr;
    logic [15:0]       ram_wdata;
    logic              ram_we;
    logic [7:0]        csum;
    logic [15:0]       remaining;
    logic [7:0]        addr_hi;
    logic [7:0]        cnt_hi;
    logic [7:0]        data_hi;
    logic              booted;
    logic              xfer;

    // Handshake: a byte moves when in_valid and in_ready are both high on a rising clk edge;
    // in_ready drops only for the single WRITE cycle, and a held byte waits there unchanged.
    assign bus.in_ready  = (state != S_WRITE);
    assign xfer          = bus.in_valid && bus.in_ready;
    assign busy          = (state != S_IDLE);
    assign fsm_state     = state;
    assign bus.ram_sel   = ram_sel;
    assign bus.ram_addr  = ram_addr;
    assign bus.ram_wdata = ram_wdata;
    assign bus.ram_we    = ram_we;

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            state        <= S_IDLE;
            cpu_resetq   <= 1'b0;
            ram_sel      <= 1'b1;
            ram_we       <= 1'b0;
            ram_addr     <= '0;
            ram_wdata    <= '0;
            err          <= 1'b0;
            words_loaded <= '0;
            csum         <= '0;
            remaining    <= '0;
            addr_hi      <= '0;
            cnt_hi       <= '0;
            data_hi      <= '0;
            booted       <= 1'b0;
        end else begin
            booted <= 1'b1;
            ram_we <= 1'b0;
            // Free-running boot: hand the RAM back and let the CPU go on the first edge out of reset.
            if (!booted && !HOLD_AT_RESET) begin
                cpu_resetq <= 1'b1;
                ram_sel    <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (xfer && bus.in_data == SYNC_BYTE) begin
                        state        <= S_ADDR_H;
                        cpu_resetq   <= 1'b0;
                        ram_sel      <= 1'b1;
                        err          <= 1'b0;
                        csum         <= '0;
                        words_loaded <= '0;
                    end
                end
                S_ADDR_H: begin
                    if (xfer) begin
                        addr_hi <= bus.in_data;
                        csum    <= csum ^ bus.in_data;
                        state   <= S_ADDR_L;
                    end
                end
                S_ADDR_L: begin
                    if (xfer) begin
                        ram_addr <= ADDR_W'({addr_hi, bus.in_data});
                        csum     <= csum ^ bus.in_data;
                        state    <= S_CNT_H;
                    end
                end
                S_CNT_H: begin
                    if (xfer) begin
                        cnt_hi <= bus.in_data;
                        csum   <= csum ^ bus.in_data;
                        state  <= S_CNT_L;
                    end
                end
                S_CNT_L: begin
                    if (xfer) begin
                        remaining <= {cnt_hi, bus.in_data};
                        csum      <= csum ^ bus.in_data;
                        state     <= ({cnt_hi, bus.in_data} == 16'd0) ? S_CSUM : S_DATA_H;
                    end
                end
                S_DATA_H: begin
                    if (xfer) begin
                        data_hi <= bus.in_data;
                        csum    <= csum ^ bus.in_data;
                        state   <= S_DATA_L;
                    end
                end
                S_DATA_L: begin
                    if (xfer) begin
                        ram_wdata <= {data_hi, bus.in_data};
                        ram_we    <= 1'b1;
                        csum      <= csum ^ bus.in_data;
                        state     <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    ram_addr     <= ram_addr + ADDR_W'(1);
                    words_loaded <= words_loaded + (ADDR_W+1)'(1);
                    remaining    <= remaining - 16'd1;
                    state        <= (remaining == 16'd1) ? S_CSUM : S_DATA_H;
                end
                S_CSUM: begin
                    if (xfer) begin
                        // Written words stay in RAM on a bad checksum; only the CPU release is gated.
                        if (bus.in_data == csum) begin
                            cpu_resetq <= 1'b1;
                            ram_sel    <= 1'b0;
                        end else begin
                            err        <= 1'b1;
                            cpu_resetq <= 1'b0;
                            ram_sel    <= 1'b1;
                        end
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
